// File: rtl/sprite_move_sequencer.sv
// Sprite move sequencer: owns the sprite position and issues an erase/update/redraw
// handshake sequence to the sprite drawer for every accepted move request.
module sprite_move_sequencer #(
  parameter int unsigned X_INIT = 0,
  parameter int unsigned Y_INIT = 16,
  parameter int unsigned STEP   = 4,
  parameter int unsigned X_MAX  = 316,
  parameter int unsigned Y_MIN  = 0,
  parameter int unsigned Y_MAX  = 236
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move,
  input  logic [1:0] dir,
  input  logic       doneDraw,
  output logic       drawBG,
  output logic       drawChar,
  output logic [8:0] x_pos,
  output logic [7:0] y_pos,
  output logic       busy
);

  typedef enum logic [3:0] {
    START,
    INIT_DRAW,
    INIT_REL,
    IDLE,
    ERASE,
    ERASE_REL,
    UPDATE,
    DRAW,
    DRAW_REL
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] dir_q;
  logic [9:0] x_ext, y_ext;
  logic [8:0] x_new;
  logic [7:0] y_new;
  logic       blocked;

  // Boundary test on the current position, done in 10 bits so no wrap can slip through.
  always_comb begin
    x_ext   = {1'b0, x_pos};
    y_ext   = {2'b00, y_pos};
    blocked = 1'b0;
    case (dir)
      2'b00: blocked = (y_ext < 10'(Y_MIN + STEP));
      2'b01: blocked = (y_ext > 10'(Y_MAX - STEP));
      2'b10: blocked = (x_ext < 10'(STEP));
      2'b11: blocked = (x_ext > 10'(X_MAX - STEP));
      default: blocked = 1'b0;
    endcase
  end

  always_comb begin
    x_new = x_pos;
    y_new = y_pos;
    case (dir_q)
      2'b00: y_new = 8'(y_ext - 10'(STEP));
      2'b01: y_new = 8'(y_ext + 10'(STEP));
      2'b10: x_new = 9'(x_ext - 10'(STEP));
      2'b11: x_new = 9'(x_ext + 10'(STEP));
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= START;
      x_pos <= 9'(X_INIT);
      y_pos <= 8'(Y_INIT);
      dir_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && move && !blocked) dir_q <= dir;
      if (state == UPDATE) begin
        x_pos <= x_new;
        y_pos <= y_new;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    drawBG    = 1'b0;
    drawChar  = 1'b0;
    busy      = 1'b1;
    case (state)
      START:     state_nxt = INIT_DRAW;
      INIT_DRAW: begin
        drawChar = 1'b1;
        if (doneDraw) state_nxt = INIT_REL;
      end
      INIT_REL:  if (!doneDraw) state_nxt = IDLE;
      IDLE: begin
        busy = 1'b0;
        if (move && !blocked) state_nxt = ERASE;
      end
      ERASE: begin
        drawBG = 1'b1;
        if (doneDraw) state_nxt = ERASE_REL;
      end
      ERASE_REL: if (!doneDraw) state_nxt = UPDATE;
      UPDATE:    state_nxt = DRAW;
      DRAW: begin
        drawChar = 1'b1;
        if (doneDraw) state_nxt = DRAW_REL;
      end
      DRAW_REL:  if (!doneDraw) state_nxt = IDLE;
      default:   state_nxt = START;
    endcase
  end

endmodule

// File: tb/tb_sprite_move_sequencer.sv
// Bench for sprite_move_sequencer: drawer model plus a scoreboard of expected
// draw requests (kind and position) pushed when a move is issued.
module tb_sprite_move_sequencer;

  logic       clock = 1'b0;
  logic       reset, move, doneDraw;
  logic [1:0] dir;
  logic       drawBG, drawChar, busy;
  logic [8:0] x_pos;
  logic [7:0] y_pos;

  always #5 clock = ~clock;

  sprite_move_sequencer #(
    .X_INIT(0), .Y_INIT(16), .STEP(4), .X_MAX(316), .Y_MIN(0), .Y_MAX(236)
  ) dut (
    .clock(clock), .reset(reset), .move(move), .dir(dir), .doneDraw(doneDraw),
    .drawBG(drawBG), .drawChar(drawChar), .x_pos(x_pos), .y_pos(y_pos), .busy(busy)
  );

  typedef struct {
    int kind;  // 0 = background erase, 1 = sprite draw
    int x;
    int y;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mx, my;
  int   hold_extra = 0;
  logic pbg = 1'b0, pch = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_req(input int kind, input int x, input int y);
    req_t r;
    r.kind = kind;
    r.x    = x;
    r.y    = y;
    exp_q.push_back(r);
  endtask

  // Drawer model: doneDraw two cycles into a request, held hold_extra cycles after it drops.
  initial begin
    int cnt, hcnt;
    cnt = 0;
    hcnt = 0;
    doneDraw = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        doneDraw = 1'b0;
        cnt = 0;
        hcnt = 0;
      end else if (!doneDraw) begin
        if (drawBG || drawChar) begin
          cnt++;
          if (cnt >= 2) begin
            doneDraw = 1'b1;
            cnt = 0;
          end
        end else cnt = 0;
      end else if (!(drawBG || drawChar)) begin
        if (hcnt >= hold_extra) begin
          doneDraw = 1'b0;
          hcnt = 0;
        end else hcnt++;
      end
    end
  end

  // Request monitor: every rising request edge is matched against the scoreboard.
  initial begin
    req_t e;
    forever begin
      @(negedge clock);
      if (drawBG && drawChar) check_val("req_overlap", 1, 0);
      if ((drawBG && !pbg) || (drawChar && !pch)) begin
        if (exp_q.size() == 0) check_val("unexpected_req", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_val("req_kind", drawChar ? 1 : 0, e.kind);
          check_val("req_x", x_pos, e.x);
          check_val("req_y", y_pos, e.y);
        end
      end
      pbg = drawBG;
      pch = drawChar;
    end
  end

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    check_val("idle_reached", busy, 0);
  endtask

  task automatic do_move(input logic [1:0] d, input bit spurious);
    bit blk;
    int n;
    case (d)
      2'b00: blk = (my < 4);
      2'b01: blk = (my > 232);
      2'b10: blk = (mx < 4);
      default: blk = (mx > 312);
    endcase
    if (!blk) begin
      push_req(0, mx, my);
      case (d)
        2'b00: my -= 4;
        2'b01: my += 4;
        2'b10: mx -= 4;
        default: mx += 4;
      endcase
      push_req(1, mx, my);
    end
    move = 1'b1;
    dir  = d;
    @(negedge clock);
    move = 1'b0;
    if (blk) begin
      repeat (4) begin
        check_val("blocked_busy", busy, 0);
        @(negedge clock);
      end
    end else begin
      if (spurious) begin
        n = 0;
        while (!drawChar && n < 100) begin
          @(negedge clock);
          n++;
        end
        check_val("draw_seen", drawChar, 1);
        move = 1'b1;
        dir  = 2'b00;
        @(negedge clock);
        move = 1'b0;
      end
      wait_idle(200);
      check_val("pos_x", x_pos, mx);
      check_val("pos_y", y_pos, my);
    end
    check_val("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    reset = 1'b1;
    move  = 1'b0;
    dir   = 2'b00;
    mx = 0;
    my = 16;
    repeat (3) @(negedge clock);
    check_val("rst_busy", busy, 1);
    check_val("rst_drawBG", drawBG, 0);
    check_val("rst_drawChar", drawChar, 0);
    check_val("rst_x", x_pos, 0);
    check_val("rst_y", y_pos, 16);

    push_req(1, 0, 16);
    reset = 1'b0;
    check_val("start_no_draw", drawChar, 0);
    @(negedge clock);
    check_val("init_draw_rise", drawChar, 1);
    wait_idle(100);

    do_move(2'b10, 1'b0);  // left at x=0: blocked
    do_move(2'b11, 1'b0);  // (0,16) -> (4,16)
    do_move(2'b11, 1'b1);  // (4,16) -> (8,16), stray move during DRAW

    // Long doneDraw hold after the erase.
    hold_extra = 4;
    push_req(0, 8, 16);
    my = 20;
    push_req(1, 8, 20);
    move = 1'b1;
    dir  = 2'b01;
    @(negedge clock);
    move = 1'b0;
    n = 0;
    while (!doneDraw && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("hold_done_seen", doneDraw, 1);
    @(negedge clock);
    n = 0;
    while (doneDraw && n < 20) begin
      check_val("hold_req_low", drawBG | drawChar, 0);
      check_val("hold_busy", busy, 1);
      check_val("hold_y", y_pos, 16);
      n++;
      @(negedge clock);
    end
    check_val("hold_len", n, 4);
    wait_idle(200);
    hold_extra = 0;
    check_val("hold_pos_y", y_pos, 20);
    check_val("hold_pos_x", x_pos, 8);

    // Reset in the middle of an erase at x=8.
    push_req(0, 8, 20);
    push_req(1, 8, 24);
    move = 1'b1;
    dir  = 2'b01;
    @(negedge clock);
    move = 1'b0;
    n = 0;
    while (!drawBG && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("erase_x", x_pos, 8);
    reset = 1'b1;
    @(negedge clock);
    check_val("mid_rst_drawBG", drawBG, 0);
    check_val("mid_rst_x", x_pos, 0);
    check_val("mid_rst_y", y_pos, 16);
    check_val("mid_rst_busy", busy, 1);
    exp_q.delete();
    mx = 0;
    my = 16;
    push_req(1, 0, 16);
    reset = 1'b0;
    @(negedge clock);
    check_val("reinit_draw_rise", drawChar, 1);
    wait_idle(100);

    // Walk down to the bottom edge, then confirm the down move is refused.
    for (int i = 0; i < 55; i++) do_move(2'b01, 1'b0);
    check_val("y_at_max", y_pos, 236);
    do_move(2'b01, 1'b0);
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
